traffic_intersection_ctrl: RTL and testbench

Parametrised two-road intersection controller with north-south (NS) and east-west (EW) signal heads, a latched pedestrian crossing phase, all-red clearance intervals, and a flashing-red fail-safe mode. Phase durations are counted in `tick_en` pulses, so the block runs from the system clock with a shared prescaler strobe. It supersedes the fixed three-state single-head sequencer and drives the signal-head and pedestrian-lamp drivers directly.

---
 rtl/traffic_intersection_ctrl.sv | 153 +++++++++++++++
 tb/tb_traffic_intersection_ctrl.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/traffic_intersection_ctrl.sv
// traffic_intersection_ctrl
//
// Two-road intersection controller. It sequences the NS and EW signal heads
// through green, yellow and all-red clearance. A latched pedestrian request
// adds a walk phase after EW yellow. A flashing-red fail-safe mode overrides
// the normal sequence. Phase durations are counted in tick_en strobes.
//
// Ports:
//   clk        system clock, rising-edge active
//   rst        asynchronous active-low reset
//   tick_en    one-cycle timing strobe; phase counters advance only on it
//   ped_req    pedestrian button (level or pulse), latched internally
//   flash_mode fail-safe request; the block holds FLASH while it is high
//   ns_red / ns_yellow / ns_green   north-south signal head
//   ew_red / ew_yellow / ew_green   east-west signal head
//   ped_walk   pedestrian walk lamp
//   phase      current state encoding, for debug and monitoring
module traffic_intersection_ctrl #(
    parameter int CNT_W        = 8,
    parameter int GREEN_TICKS  = 20,
    parameter int YELLOW_TICKS = 4,
    parameter int ALLRED_TICKS = 2,
    parameter int PED_TICKS    = 10
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick_en,
    input  logic       ped_req,
    input  logic       flash_mode,
    output logic       ns_red,
    output logic       ns_yellow,
    output logic       ns_green,
    output logic       ew_red,
    output logic       ew_yellow,
    output logic       ew_green,
    output logic       ped_walk,
    output logic [2:0] phase
);

    if (GREEN_TICKS  < 1 || GREEN_TICKS  > (1 << CNT_W) ||
        YELLOW_TICKS < 1 || YELLOW_TICKS > (1 << CNT_W) ||
        ALLRED_TICKS < 1 || ALLRED_TICKS > (1 << CNT_W) ||
        PED_TICKS    < 1 || PED_TICKS    > (1 << CNT_W)) begin : g_bad_duration
        $error("traffic_intersection_ctrl: every duration must lie in 1 .. 2**CNT_W");
    end

    typedef enum logic [2:0] {
        ALLRED_A  = 3'd0,
        NS_GREEN  = 3'd1,
        NS_YELLOW = 3'd2,
        ALLRED_B  = 3'd3,
        EW_GREEN  = 3'd4,
        EW_YELLOW = 3'd5,
        PED_WALK  = 3'd6,
        FLASH     = 3'd7
    } state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             ped_pend, ped_pend_nxt;
    logic             blink, blink_nxt;

    // Counter reload value (duration - 1) for a state about to be entered.
    function automatic logic [CNT_W-1:0] load_val(input state_t s);
        case (s)
            NS_GREEN, EW_GREEN:   load_val = CNT_W'(GREEN_TICKS - 1);
            NS_YELLOW, EW_YELLOW: load_val = CNT_W'(YELLOW_TICKS - 1);
            PED_WALK:             load_val = CNT_W'(PED_TICKS - 1);
            ALLRED_A, ALLRED_B:   load_val = CNT_W'(ALLRED_TICKS - 1);
            default:              load_val = '0;
        endcase
    endfunction

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= ALLRED_A;
            cnt      <= CNT_W'(ALLRED_TICKS - 1);
            ped_pend <= 1'b0;
            blink    <= 1'b0;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            ped_pend <= ped_pend_nxt;
            blink    <= blink_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        cnt_nxt      = cnt;
        ped_pend_nxt = ped_pend;
        blink_nxt    = blink;
        if (flash_mode) begin
            // Fail-safe wins over everything. The blink flop starts low on
            // entry, and tick_en is ignored on the entry cycle.
            state_nxt    = FLASH;
            ped_pend_nxt = 1'b0;
            blink_nxt    = (state == FLASH) ? (blink ^ tick_en) : 1'b0;
        end else if (state == FLASH) begin
            state_nxt    = ALLRED_A;
            cnt_nxt      = load_val(ALLRED_A);
            blink_nxt    = 1'b0;
            ped_pend_nxt = 1'b0;
        end else begin
            if (ped_req && state != PED_WALK) begin
                ped_pend_nxt = 1'b1;
            end
            if (tick_en) begin
                if (cnt != '0) begin
                    cnt_nxt = cnt - CNT_W'(1);
                end else begin
                    case (state)
                        ALLRED_A:  state_nxt = NS_GREEN;
                        NS_GREEN:  state_nxt = NS_YELLOW;
                        NS_YELLOW: state_nxt = ALLRED_B;
                        ALLRED_B:  state_nxt = EW_GREEN;
                        EW_GREEN:  state_nxt = EW_YELLOW;
                        // A request arriving on the decision cycle itself
                        // still gets the walk phase.
                        EW_YELLOW: state_nxt = (ped_pend || ped_req) ? PED_WALK : ALLRED_A;
                        default:   state_nxt = ALLRED_A;
                    endcase
                    cnt_nxt = load_val(state_nxt);
                    if (state_nxt == PED_WALK) begin
                        ped_pend_nxt = 1'b0;
                    end
                end
            end
        end
    end

    always_comb begin
        ns_red    = 1'b0;
        ns_yellow = 1'b0;
        ns_green  = 1'b0;
        ew_red    = 1'b0;
        ew_yellow = 1'b0;
        ew_green  = 1'b0;
        ped_walk  = 1'b0;
        case (state)
            NS_GREEN:  begin ns_green  = 1'b1; ew_red = 1'b1; end
            NS_YELLOW: begin ns_yellow = 1'b1; ew_red = 1'b1; end
            EW_GREEN:  begin ew_green  = 1'b1; ns_red = 1'b1; end
            EW_YELLOW: begin ew_yellow = 1'b1; ns_red = 1'b1; end
            PED_WALK:  begin ns_red = 1'b1; ew_red = 1'b1; ped_walk = 1'b1; end
            FLASH:     begin ns_red = blink; ew_red = blink; end
            default:   begin ns_red = 1'b1; ew_red = 1'b1; end
        endcase
    end

    assign phase = state;

endmodule

// File: tb/tb_traffic_intersection_ctrl.sv
// Self-checking bench for traffic_intersection_ctrl. A behavioural model
// predicts the registered state for every driven cycle. Its expected output
// word is queued at drive time and compared once the clock edge has
// produced the DUT output.
module tb_traffic_intersection_ctrl;

    localparam int GRN = 5;
    localparam int YEL = 2;
    localparam int ALR = 1;
    localparam int PED = 3;

    logic       clk;
    logic       rst;
    logic       tick_en;
    logic       ped_req;
    logic       flash_mode;
    logic       ns_red, ns_yellow, ns_green;
    logic       ew_red, ew_yellow, ew_green;
    logic       ped_walk;
    logic [2:0] phase;

    traffic_intersection_ctrl #(
        .CNT_W        (8),
        .GREEN_TICKS  (GRN),
        .YELLOW_TICKS (YEL),
        .ALLRED_TICKS (ALR),
        .PED_TICKS    (PED)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .tick_en    (tick_en),
        .ped_req    (ped_req),
        .flash_mode (flash_mode),
        .ns_red     (ns_red),
        .ns_yellow  (ns_yellow),
        .ns_green   (ns_green),
        .ew_red     (ew_red),
        .ew_yellow  (ew_yellow),
        .ew_green   (ew_green),
        .ped_walk   (ped_walk),
        .phase      (phase)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    int ped_seen = 0;

    logic [9:0] exp_q[$];

    // Model state: the phase, the ticks elapsed in it, the pending request
    // and the flash blink.
    int   m_state;
    int   m_elapsed;
    logic m_pend;
    logic m_blink;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int dur(input int s);
        case (s)
            1, 4:    dur = GRN;
            2, 5:    dur = YEL;
            6:       dur = PED;
            default: dur = ALR;
        endcase
    endfunction

    // {phase[2:0], ns_r, ns_y, ns_g, ew_r, ew_y, ew_g, ped_walk}
    function automatic logic [9:0] exp_out(input int s, input logic b);
        logic [2:0] p;
        p = 3'(s);
        case (s)
            1:       exp_out = {p, 7'b0011000};
            2:       exp_out = {p, 7'b0101000};
            4:       exp_out = {p, 7'b1000010};
            5:       exp_out = {p, 7'b1000100};
            6:       exp_out = {p, 7'b1001001};
            7:       exp_out = {p, b, 2'b00, b, 3'b000};
            default: exp_out = {p, 7'b1001000};
        endcase
    endfunction

    task automatic model_reset();
        m_state   = 0;
        m_elapsed = 0;
        m_pend    = 1'b0;
        m_blink   = 1'b0;
    endtask

    task automatic model_next(input logic t, input logic p, input logic f);
        logic np;
        if (f) begin
            m_blink   = (m_state == 7) ? (m_blink ^ t) : 1'b0;
            m_state   = 7;
            m_pend    = 1'b0;
            m_elapsed = 0;
        end else if (m_state == 7) begin
            m_state   = 0;
            m_elapsed = 0;
            m_blink   = 1'b0;
            m_pend    = 1'b0;
        end else begin
            np = m_pend | (p && m_state != 6);
            if (t) begin
                if (m_elapsed + 1 >= dur(m_state)) begin
                    m_elapsed = 0;
                    if (m_state == 5) m_state = (m_pend || p) ? 6 : 0;
                    else if (m_state == 6) m_state = 0;
                    else m_state = m_state + 1;
                    if (m_state == 6) np = 1'b0;
                end else begin
                    m_elapsed++;
                end
            end
            m_pend = np;
        end
    endtask

    task automatic step(input logic t, input logic p, input logic f);
        logic [9:0] e;
        logic [9:0] got;
        tick_en    = t;
        ped_req    = p;
        flash_mode = f;
        model_next(t, p, f);
        exp_q.push_back(exp_out(m_state, m_blink));
        @(posedge clk);
        @(negedge clk);
        got = {phase, ns_red, ns_yellow, ns_green, ew_red, ew_yellow, ew_green, ped_walk};
        e   = exp_q.pop_front();
        check_eq("phase", 32'(got[9:7]), 32'(e[9:7]));
        check_eq("lamps", 32'(got[6:0]), 32'(e[6:0]));
        check_eq("safe_heads", 32'(!((ns_green | ns_yellow) && (ew_green | ew_yellow))), 32'd1);
        check_eq("safe_walk", 32'(!ped_walk || (ns_red && ew_red)), 32'd1);
        if (phase == 3'd6) ped_seen++;
    endtask

    task automatic run_until_state(input int s);
        for (int k = 0; k < 100; k++) begin
            if (m_state == s) break;
            step(1'b1, 1'b0, 1'b0);
        end
    endtask

    initial begin
        rst        = 1'b0;
        tick_en    = 1'b0;
        ped_req    = 1'b0;
        flash_mode = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        check_eq("reset_phase", 32'(phase), 32'd0);
        check_eq("reset_lamps",
                 32'({ns_red, ns_yellow, ns_green, ew_red, ew_yellow, ew_green, ped_walk}),
                 32'(exp_out(0, 1'b0) & 10'h07f));
        rst = 1'b1;

        // Two plain periods, no requests.
        ped_seen = 0;
        for (int i = 0; i < 32; i++) step(1'b1, 1'b0, 1'b0);
        check_eq("no_ped_plain", 32'(ped_seen), 32'd0);

        // One-cycle request during NS green: one walk phase, then none.
        run_until_state(1);
        ped_seen = 0;
        step(1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 40; i++) step(1'b1, 1'b0, 1'b0);
        check_eq("ped_cycles_ns", 32'(ped_seen), 32'(PED));

        // Request on the final EW yellow cycle, then a dropped request in walk.
        ped_seen = 0;
        for (int k = 0; k < 100; k++) begin
            if (m_state == 5 && m_elapsed == YEL - 1) break;
            step(1'b1, 1'b0, 1'b0);
        end
        step(1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 25; i++) step(1'b1, 1'b0, 1'b0);
        check_eq("ped_cycles_late", 32'(ped_seen), 32'(PED));

        // Sparse strobes: one tick every fourth cycle; ped requests mixed in.
        for (int i = 0; i < 80; i++) step(1'(i % 4 == 0), 1'(i == 9), 1'b0);

        // Flash during EW green with a request pending.
        run_until_state(1);
        step(1'b1, 1'b1, 1'b0);
        run_until_state(4);
        step(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 12; i++) step(1'(i % 3 != 1), 1'(i % 4 == 0), 1'b1);
        ped_seen = 0;
        for (int i = 0; i < 20; i++) step(1'b1, 1'b0, 1'b0);
        check_eq("no_ped_after_flash", 32'(ped_seen), 32'd0);

        // Asynchronous reset mid NS yellow.
        run_until_state(2);
        #1 rst = 1'b0;
        #1;
        model_reset();
        check_eq("async_phase", 32'(phase), 32'd0);
        check_eq("async_lamps",
                 32'({ns_red, ns_yellow, ns_green, ew_red, ew_yellow, ew_green, ped_walk}),
                 32'(exp_out(0, 1'b0) & 10'h07f));
        tick_en = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 18; i++) step(1'b1, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
